// File: rtl/seg_scan_display.sv
// seg_scan_display
// Multi-digit seven-segment display engine. A binary value captured on a
// load pulse is turned into hex nibbles directly, or into decimal digits by
// a sequential double-dabble converter. The committed digits are scanned
// one at a time onto a shared segment bus, with optional leading-zero
// blanking and a dash pattern when a decimal value does not fit.
module seg_scan_display #(
    parameter int WIDTH          = 16,
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  dec_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  ovf,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    // The BCD accumulator holds one spare nibble beyond what WIDTH bits need,
    // so values too large for NUM_DIGITS still convert correctly and can be
    // flagged as overflow instead of wrapping.
    localparam int BCD_W = 4 * ((WIDTH + 2) / 3 + 1);
    localparam int NBCD  = BCD_W / 4;
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int EXT_W = BCD_W + DIG_W;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]      shift_cnt;
    logic [WIDTH-1:0]      bin_sr;
    logic [BCD_W-1:0]      bcd_sr;
    logic [BCD_W-1:0]      bcd_adj;
    logic                  is_dec;
    logic                  blank_req;
    logic [DIG_W-1:0]      digits;
    logic                  blank_flag;
    logic                  ovf_r;

    logic [EXT_W-1:0]      bcd_ext;
    logic [DIG_W-1:0]      hex_digits;
    logic [DIG_W-1:0]      commit_digits;
    logic                  commit_ovf;

    logic [REF_W-1:0]      refresh_cnt;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic                  upper_zero;
    logic [7:0]            pattern_al;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [7:0]            seg_r;
    logic [NUM_DIGITS-1:0] an_r;

    // Active-low {dp,g,f,e,d,c,b,a} glyphs for one hex digit; dp stays off.
    function automatic logic [7:0] seg_lut(input logic [3:0] d);
        case (d)
            4'h0: seg_lut = 8'hC0;
            4'h1: seg_lut = 8'hF9;
            4'h2: seg_lut = 8'hA4;
            4'h3: seg_lut = 8'hB0;
            4'h4: seg_lut = 8'h99;
            4'h5: seg_lut = 8'h92;
            4'h6: seg_lut = 8'h82;
            4'h7: seg_lut = 8'hF8;
            4'h8: seg_lut = 8'h80;
            4'h9: seg_lut = 8'h90;
            4'hA: seg_lut = 8'h88;
            4'hB: seg_lut = 8'h83;
            4'hC: seg_lut = 8'hC6;
            4'hD: seg_lut = 8'hA1;
            4'hE: seg_lut = 8'h86;
            default: seg_lut = 8'h8E;
        endcase
    endfunction

    // Next-state logic: hex goes straight to COMMIT, decimal runs WIDTH shift steps first.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = dec_mode ? CONVERT : COMMIT;
                end
            end
            CONVERT: begin
                if (shift_cnt == CNT_W'(WIDTH - 1)) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; clear aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NBCD; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digits and overflow that COMMIT will latch, chosen by the captured mode.
    always_comb begin
        bcd_ext                 = '0;
        bcd_ext[BCD_W-1:0]      = bcd_sr;
        hex_digits              = '0;
        hex_digits[WIDTH-1:0]   = bin_sr;
        if (is_dec) begin
            commit_digits = bcd_ext[DIG_W-1:0];
            commit_ovf    = |bcd_ext[EXT_W-1:DIG_W];
        end else begin
            commit_digits = hex_digits;
            commit_ovf    = 1'b0;
        end
    end

    // Conversion datapath and committed display registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            shift_cnt  <= '0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            is_dec     <= 1'b0;
            blank_req  <= 1'b0;
            digits     <= '0;
            blank_flag <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr    <= value;
                        bcd_sr    <= '0;
                        shift_cnt <= '0;
                        is_dec    <= dec_mode;
                        blank_req <= blank_lz;
                    end
                end
                CONVERT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    shift_cnt        <= shift_cnt + 1'b1;
                end
                COMMIT: begin
                    digits     <= commit_digits;
                    blank_flag <= blank_req;
                    ovf_r      <= commit_ovf;
                end
                default: ;
            endcase
        end
    end

    // Scan timer: hold each digit for REFRESH_DIV cycles, then step to the next one.
    always_ff @(posedge clk) begin
        if (clear) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Select the scanned digit; walking from the top tracks whether it and everything above are zero.
    always_comb begin
        cur_nibble = 4'd0;
        cur_blank  = 1'b0;
        upper_zero = 1'b1;
        an_onehot  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (digits[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
            if (IDX_W'(i) == idx) begin
                cur_nibble   = digits[4*i +: 4];
                cur_blank    = blank_flag && (i != 0) && upper_zero;
                an_onehot[i] = 1'b1;
            end
        end
        if (ovf_r) begin
            pattern_al = 8'hBF;
        end else if (cur_blank) begin
            pattern_al = 8'hFF;
        end else begin
            pattern_al = seg_lut(cur_nibble);
        end
    end

    // Registered segment and anode drive in the configured polarity.
    always_ff @(posedge clk) begin
        if (clear) begin
            seg_r <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
            an_r  <= SEG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
        end else begin
            seg_r <= SEG_ACTIVE_LOW ? pattern_al : ~pattern_al;
            an_r  <= SEG_ACTIVE_LOW ? ~an_onehot : an_onehot;
        end
    end

    assign busy = (state != IDLE);
    assign ovf  = ovf_r;
    assign seg  = seg_r;
    assign an   = an_r;

endmodule
